// File: rtl/csr_pkg.sv
// Shared constants and state types for the AXI4-Lite CSR slave and its register file.
package csr_pkg;

  localparam int CSR_REG_NUM_DEF  = 32;
  localparam int LOG2_REG_NUM_DEF = 5;

  localparam int CTRL_IDX   = 0;
  localparam int STATUS_IDX = 1;

  localparam int START_BIT  = 0;
  localparam int IRQ_EN_BIT = 1;
  localparam int BUSY_BIT   = 0;
  localparam int DONE_BIT   = 1;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_VALID
  } rd_state_e;

endpackage

// File: rtl/csr_regfile.sv
// Accelerator CSR storage: byte-strobed write port, combinational read port,
// START/BUSY/DONE tracking and the level interrupt.
module csr_regfile
  import csr_pkg::*;
#(
  parameter int CSR_REG_NUM  = CSR_REG_NUM_DEF,
  parameter int LOG2_REG_NUM = LOG2_REG_NUM_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en_i,
  input  logic [LOG2_REG_NUM-1:0]   wr_idx_i,
  input  logic [31:0]               wr_data_i,
  input  logic [3:0]                wr_strb_i,
  input  logic [LOG2_REG_NUM-1:0]   rd_idx_i,
  output logic [31:0]               rd_data_o,
  input  logic                      done_i,
  output logic                      start_o,
  output logic                      irq_o,
  output logic [CSR_REG_NUM*32-1:0] csr_reg_o
);

  logic [31:0] regs_q [CSR_REG_NUM];
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        start_q, start_d;
  logic        irq_q;
  logic [31:0] status_word;
  logic [31:0] wr_merged;
  logic [31:0] wr_value;
  logic        w1c_done;

  always_comb begin
    status_word           = '0;
    status_word[BUSY_BIT] = busy_q;
    status_word[DONE_BIT] = done_q;

    for (int b = 0; b < 4; b++) begin
      wr_merged[8*b +: 8] = wr_strb_i[b] ? wr_data_i[8*b +: 8] : regs_q[wr_idx_i][8*b +: 8];
    end

    // START is a pulse, never stored, so CTRL bit0 always reads back as 0
    wr_value = wr_merged;
    if (wr_idx_i == LOG2_REG_NUM'(CTRL_IDX)) begin
      wr_value[START_BIT] = 1'b0;
    end

    start_d  = wr_en_i && (wr_idx_i == LOG2_REG_NUM'(CTRL_IDX)) && wr_strb_i[START_BIT/8]
               && wr_data_i[START_BIT] && !busy_q;
    w1c_done = wr_en_i && (wr_idx_i == LOG2_REG_NUM'(STATUS_IDX)) && wr_strb_i[DONE_BIT/8]
               && wr_data_i[DONE_BIT];

    busy_d = busy_q;
    if (done_i)  busy_d = 1'b0;
    if (start_d) busy_d = 1'b1;

    // a completion arriving with the clear must not be lost
    done_d = done_q;
    if (w1c_done) done_d = 1'b0;
    if (done_i)   done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CSR_REG_NUM; i++) regs_q[i] <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      for (int i = 0; i < CSR_REG_NUM; i++) begin
        if (wr_en_i && (wr_idx_i == LOG2_REG_NUM'(i)) && (i != STATUS_IDX)) begin
          regs_q[i] <= wr_value;
        end
      end
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= start_d;
      irq_q   <= done_q & regs_q[CTRL_IDX][IRQ_EN_BIT];
    end
  end

  always_comb begin
    rd_data_o = regs_q[rd_idx_i];
    if (rd_idx_i == LOG2_REG_NUM'(STATUS_IDX)) rd_data_o = status_word;

    for (int i = 0; i < CSR_REG_NUM; i++) csr_reg_o[32*i +: 32] = regs_q[i];
    csr_reg_o[32*STATUS_IDX +: 32] = status_word;
  end

  assign start_o = start_q;
  assign irq_o   = irq_q;

endmodule

// File: rtl/axi_lite_csr_slave.sv
// AXI4-Lite responder for the accelerator CSR file; write and read handshake FSMs
// in front of csr_regfile.
//
// write FSM   | meaning
// WR_IDLE     | nothing held; AW and W both accepted
// WR_HAVE_AW  | address held, waiting for data
// WR_HAVE_W   | data held, waiting for address
// WR_RESP     | committed, BVALID high until BREADY
// read FSM    | meaning
// RD_IDLE     | ARREADY high once initialised
// RD_VALID    | RVALID high, RDATA frozen until RREADY
module axi_lite_csr_slave
  import csr_pkg::*;
#(
  parameter int CSR_REG_NUM  = CSR_REG_NUM_DEF,
  parameter int LOG2_REG_NUM = LOG2_REG_NUM_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [LOG2_REG_NUM+1:0]   S_AXI_AWADDR,
  input  logic [2:0]                S_AXI_AWPROT,
  input  logic [31:0]               S_AXI_WDATA,
  input  logic [3:0]                S_AXI_WSTRB,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  input  logic [LOG2_REG_NUM+1:0]   S_AXI_ARADDR,
  input  logic [2:0]                S_AXI_ARPROT,
  output logic [31:0]               S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY,
  output logic [CSR_REG_NUM*32-1:0] csr_reg_o,
  output logic                      start_o,
  input  logic                      done_i,
  output logic                      irq_o
);

  wr_state_e                 wr_state_q, wr_state_d;
  rd_state_e                 rd_state_q, rd_state_d;
  logic                      init_q;
  logic [LOG2_REG_NUM-1:0]   aw_idx_q;
  logic [31:0]               w_data_q;
  logic [3:0]                w_strb_q;
  logic [31:0]               rdata_q;
  logic                      aw_hs, w_hs, ar_hs, commit;
  logic [LOG2_REG_NUM-1:0]   wr_idx;
  logic [31:0]               wr_data;
  logic [3:0]                wr_strb;
  logic [31:0]               rd_data;
  logic                      unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    wr_state_d    = wr_state_q;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    commit        = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        S_AXI_AWREADY = init_q;
        S_AXI_WREADY  = init_q;
        if (init_q && S_AXI_AWVALID && S_AXI_WVALID) begin
          commit     = 1'b1;
          wr_state_d = WR_RESP;
        end else if (init_q && S_AXI_AWVALID) begin
          wr_state_d = WR_HAVE_AW;
        end else if (init_q && S_AXI_WVALID) begin
          wr_state_d = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: begin
        S_AXI_WREADY = init_q;
        if (init_q && S_AXI_WVALID) begin
          commit     = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_HAVE_W: begin
        S_AXI_AWREADY = init_q;
        if (init_q && S_AXI_AWVALID) begin
          commit     = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d    = rd_state_q;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        S_AXI_ARREADY = init_q;
        if (init_q && S_AXI_ARVALID) rd_state_d = RD_VALID;
      end
      RD_VALID: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // whichever half arrives in the commit cycle comes straight from the bus
  assign wr_idx  = (wr_state_q == WR_HAVE_AW) ? aw_idx_q : S_AXI_AWADDR[LOG2_REG_NUM+1:2];
  assign wr_data = (wr_state_q == WR_HAVE_W)  ? w_data_q : S_AXI_WDATA;
  assign wr_strb = (wr_state_q == WR_HAVE_W)  ? w_strb_q : S_AXI_WSTRB;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      init_q     <= 1'b0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      init_q     <= 1'b1;
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[LOG2_REG_NUM+1:2];
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (ar_hs) rdata_q <= rd_data;
    end
  end

  csr_regfile #(
    .CSR_REG_NUM  (CSR_REG_NUM),
    .LOG2_REG_NUM (LOG2_REG_NUM)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (commit),
    .wr_idx_i  (wr_idx),
    .wr_data_i (wr_data),
    .wr_strb_i (wr_strb),
    .rd_idx_i  (S_AXI_ARADDR[LOG2_REG_NUM+1:2]),
    .rd_data_o (rd_data),
    .done_i    (done_i),
    .start_o   (start_o),
    .irq_o     (irq_o),
    .csr_reg_o (csr_reg_o)
  );

  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_BRESP = AXI_RESP_OKAY;
  assign S_AXI_RRESP = AXI_RESP_OKAY;

endmodule

// File: tb/tb_axi_lite_csr_slave.sv
// Directed bench for axi_lite_csr_slave with a register-level model checked every cycle.
module tb_axi_lite_csr_slave;

  localparam int N  = 32;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          S_AXI_AWVALID = 1'b0, S_AXI_AWREADY;
  logic [AW-1:0] S_AXI_AWADDR = '0;
  logic [2:0]    S_AXI_AWPROT = '0;
  logic [31:0]   S_AXI_WDATA = '0;
  logic [3:0]    S_AXI_WSTRB = '0;
  logic          S_AXI_WVALID = 1'b0, S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID, S_AXI_BREADY = 1'b0;
  logic          S_AXI_ARVALID = 1'b0, S_AXI_ARREADY;
  logic [AW-1:0] S_AXI_ARADDR = '0;
  logic [2:0]    S_AXI_ARPROT = '0;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID, S_AXI_RREADY = 1'b0;
  logic [N*32-1:0] csr_reg_o;
  logic          start_o, irq_o;
  logic          done_i = 1'b0;

  axi_lite_csr_slave #(.CSR_REG_NUM(N), .LOG2_REG_NUM(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_AWADDR(S_AXI_AWADDR),
    .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY), .csr_reg_o(csr_reg_o), .start_o(start_o),
    .done_i(done_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = -100;
  int start_count = 0;
  logic [31:0] exp_regs [N];
  bit exp_busy = 1'b0, exp_done = 1'b0;
  bit irq_last = 1'b0;

  task automatic chk(input string name, input logic [N*32-1:0] act, input logic [N*32-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: CTRL holds IRQ_EN etc. with bit0 never stored, STATUS is {DONE,BUSY}.
  function automatic logic [31:0] model_read(input int idx);
    if (idx == 1) return {30'b0, exp_done, exp_busy};
    return exp_regs[idx];
  endfunction

  function automatic logic [N*32-1:0] model_image();
    logic [N*32-1:0] img;
    for (int i = 0; i < N; i++) img[32*i +: 32] = model_read(i);
    return img;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) exp_regs[i] = '0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    start_cyc = -100;
  endtask

  task automatic model_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    logic [31:0] nv;
    idx = int'(addr[AW-1:2]);
    nv = model_read(idx);
    for (int b = 0; b < 4; b++) if (strb[b]) nv[8*b +: 8] = data[8*b +: 8];
    if (idx == 0) begin
      exp_regs[0] = {nv[31:1], 1'b0};
      if (strb[0] && data[0] && !exp_busy) begin
        exp_busy = 1'b1;
        start_cyc = cyc;
      end
    end else if (idx == 1) begin
      if (strb[0] && data[1]) exp_done = 1'b0;
    end else begin
      exp_regs[idx] = nv;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (start_o) start_count++;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("csr_image", csr_reg_o, model_image());
      chk("start_o", start_o, cyc == start_cyc);
      chk("irq_o", irq_o, irq_last);
      irq_last = exp_done & exp_regs[0][1];
      if (S_AXI_BVALID) chk("bresp", S_AXI_BRESP, 2'b00);
      if (S_AXI_RVALID) chk("rresp", S_AXI_RRESP, 2'b00);
    end else begin
      irq_last = 1'b0;
    end
  end

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_delay, input int b_delay);
    bit aw_done = 0, w_done = 0, aw_r, w_r;
    int c = 0;
    @(posedge clk); #1;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(aw_done && w_done)) begin
      S_AXI_AWVALID = !aw_done && (c >= aw_delay);
      S_AXI_WVALID  = !w_done;
      @(negedge clk);
      if (w_done) chk("wready_after_capture", S_AXI_WREADY, 1'b0);
      aw_r = S_AXI_AWVALID & S_AXI_AWREADY;
      w_r  = S_AXI_WVALID & S_AXI_WREADY;
      @(posedge clk); #1;
      aw_done |= aw_r;
      w_done  |= w_r;
      c++;
      if (c > 40) begin
        chk("write_handshake_timeout", 1'b1, 1'b0);
        break;
      end
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    model_write(addr, data, strb);
    @(negedge clk);
    chk("bvalid_after_commit", S_AXI_BVALID, 1'b1);
    for (int i = 0; i < b_delay; i++) begin
      @(posedge clk); #1;
      S_AXI_AWADDR = 7'h24; S_AXI_WDATA = 32'hBAD0BAD0; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      @(negedge clk);
      chk("bvalid_hold", S_AXI_BVALID, 1'b1);
      chk("awready_during_resp", S_AXI_AWREADY, 1'b0);
      chk("wready_during_resp", S_AXI_WREADY, 1'b0);
    end
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    S_AXI_BREADY = 1'b0;
    @(negedge clk);
    chk("bvalid_cleared", S_AXI_BVALID, 1'b0);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input logic [31:0] exp, input int hold);
    bit got = 0, r;
    int c = 0;
    @(posedge clk); #1;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    while (!got) begin
      @(negedge clk);
      r = S_AXI_ARREADY;
      @(posedge clk); #1;
      got = r;
      c++;
      if (c > 40) begin
        chk("read_handshake_timeout", 1'b1, 1'b0);
        break;
      end
    end
    S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    chk("rvalid_after_ar", S_AXI_RVALID, 1'b1);
    chk("rdata", S_AXI_RDATA, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rvalid_hold", S_AXI_RVALID, 1'b1);
      chk("rdata_stable", S_AXI_RDATA, exp);
    end
    @(posedge clk); #1;
    S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    S_AXI_RREADY = 1'b0;
    @(negedge clk);
    chk("rvalid_cleared", S_AXI_RVALID, 1'b0);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    done_i = 1'b1;
    @(posedge clk); #1;
    done_i = 1'b0;
    exp_busy = 1'b0;
    exp_done = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc0;
    logic [31:0] old5;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("awready_before_init", S_AXI_AWREADY, 1'b0);
    chk("wready_before_init", S_AXI_WREADY, 1'b0);
    chk("arready_before_init", S_AXI_ARREADY, 1'b0);
    chk("reset_bvalid", S_AXI_BVALID, 1'b0);
    chk("reset_rvalid", S_AXI_RVALID, 1'b0);
    chk("reset_rdata", S_AXI_RDATA, 32'h0);
    chk("reset_image", csr_reg_o, '0);

    // AW+W together, then read back
    axi_write(7'h08, 32'hDEADBEEF, 4'hF, 0, 0);
    axi_read(7'h08, 32'hDEADBEEF, 0);

    // W three cycles ahead of AW with partial strobe
    axi_write(7'h0C, 32'hFFFFFFFF, 4'hF, 0, 0);
    axi_write(7'h0C, 32'h11223344, 4'b0101, 3, 0);
    chk("model_reg3", model_read(3), 32'hFF22FF44);
    axi_read(7'h0C, 32'hFF22FF44, 0);

    // BREADY held off five cycles with a competing write on the bus
    axi_write(7'h10, 32'hA5A50001, 4'hF, 0, 5);
    axi_write(7'h18, 32'h0000CAFE, 4'hF, 0, 0);
    axi_read(7'h10, 32'hA5A50001, 0);
    axi_write(7'h18, 32'h12345678, 4'h0, 0, 0);
    axi_read(7'h18, 32'h0000CAFE, 0);

    // START / BUSY / DONE / IRQ
    sc0 = start_count;
    axi_write(7'h00, 32'h3, 4'hF, 0, 0);
    chk("start_pulse_count", start_count - sc0, 1);
    axi_read(7'h04, 32'h1, 0);
    axi_read(7'h00, 32'h2, 0);
    sc0 = start_count;
    axi_write(7'h00, 32'h3, 4'hF, 0, 0);
    chk("start_ignored_when_busy", start_count - sc0, 0);
    pulse_done();
    axi_read(7'h04, 32'h2, 0);
    chk("irq_set", irq_o, 1'b1);
    axi_write(7'h04, 32'h2, 4'hF, 0, 0);
    axi_read(7'h04, 32'h0, 0);
    chk("irq_cleared", irq_o, 1'b0);

    // DONE clear and done_i in the same cycle: set wins
    fork
      axi_write(7'h04, 32'h2, 4'hF, 0, 0);
      begin
        @(posedge clk); #1;
        done_i = 1'b1;
        @(posedge clk); #2;
        done_i = 1'b0;
        exp_done = 1'b1;
        exp_busy = 1'b0;
      end
    join
    axi_read(7'h04, 32'h2, 0);
    axi_write(7'h04, 32'h2, 4'h1, 0, 0);
    axi_read(7'h04, 32'h0, 0);

    // same-cycle read and write of reg5 returns old data
    @(posedge clk); #1;
    old5 = model_read(5);
    S_AXI_AWADDR = 7'h14; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 7'h14;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    chk("rw_same_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    model_write(7'h14, 32'h55, 4'hF);
    @(negedge clk);
    chk("rw_same_old_data", S_AXI_RDATA, old5);
    chk("rw_same_old_literal", S_AXI_RDATA, 32'h0);
    chk("rw_same_bvalid", S_AXI_BVALID, 1'b1);
    @(posedge clk); #1;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    axi_read(7'h14, 32'h55, 4);

    // reset while BVALID and RVALID are up and a START is in flight
    @(posedge clk); #1;
    S_AXI_AWADDR = 7'h00; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 7'h08;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    chk("pre_reset_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_bvalid", S_AXI_BVALID, 1'b0);
    chk("rst_rvalid", S_AXI_RVALID, 1'b0);
    chk("rst_rdata", S_AXI_RDATA, 32'h0);
    chk("rst_start", start_o, 1'b0);
    chk("rst_irq", irq_o, 1'b0);
    chk("rst_image", csr_reg_o, '0);
    chk("rst_awready", S_AXI_AWREADY, 1'b0);
    @(negedge clk);
    chk("rst_start_held", start_o, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("arready_before_reinit", S_AXI_ARREADY, 1'b0);
    axi_read(7'h08, 32'h0, 0);
    axi_read(7'h04, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_csr_slave.md
Name: axi_lite_csr_slave

Overview:
AXI4-Lite responder that terminates the CPU GP port and holds the accelerator CSR file (softmax/LN/conv layer descriptors: base addresses, strides, scales). It exposes all registers as a flat vector to the compute cores. It also generates a one-cycle start pulse and tracks busy/done/interrupt from the core's completion signal. It is the slave-side counterpart of the CPU master model and is instantiated inside the top wrapper.

Parameters:
CSR_REG_NUM, 32, number of 32-bit registers (power of two)
LOG2_REG_NUM, 5, log2(CSR_REG_NUM); address width is LOG2_REG_NUM+2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
S_AXI_AWVALID/AWREADY  in/out  1/1  write address handshake
S_AXI_AWADDR  in  LOG2_REG_NUM+2  byte address; bits[1:0] ignored
S_AXI_AWPROT  in  3  ignored
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID/WREADY  in/out  1/1  write data handshake
S_AXI_BRESP  out  2  always 2'b00
S_AXI_BVALID/BREADY  out/in  1/1  write response handshake
S_AXI_ARVALID/ARREADY  in/out  1/1  read address handshake
S_AXI_ARADDR  in  LOG2_REG_NUM+2  byte address
S_AXI_ARPROT  in  3  ignored
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00
S_AXI_RVALID/RREADY  out/in  1/1  read data handshake
csr_reg_o  out  CSR_REG_NUM*32  flat register image; reg i at [32*i+:32]
start_o  out  1  one-cycle start pulse to core
done_i  in  1  one-cycle completion pulse from core
irq_o  out  1  level interrupt

Behaviour:
- Reset (async, rst_n=0): all registers 0, all *READY/BVALID/RVALID 0, RDATA 0, start_o 0, irq_o 0; pending transactions dropped immediately. A registered init flag sets on the first clk edge after release; all READYs stay 0 until it is set.
- Register map:
  - reg0 CTRL: bit0 START (write-1 pulses, reads 0); bit1 IRQ_EN (RW).
  - reg1 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, write-1-clears).
  - reg2..CSR_REG_NUM-1: plain RW.
  - Index = ADDR[LOG2_REG_NUM+1:2]; every index is in range.
- Write channel:
  - AW and W are captured independently into holding regs. AWREADY=init & !aw_held & !BVALID; WREADY=init & !w_held & !BVALID.
  - Commit occurs in the cycle both are held or handshaking. Per-byte WSTRB merge: strobe 0 keeps the old byte.
  - BVALID rises the cycle after commit (AW+W together in cycle 0 -> reg updated at end of cycle 0, BVALID=1 in cycle 1). BVALID holds until BREADY, then holding regs clear.
  - Zero-strobe write still completes with a response.
- Read channel:
  - ARREADY=init & !RVALID.
  - On handshake in cycle 0, RDATA is registered from the pre-edge register value; RVALID=1 in cycle 1 and holds, with RDATA stable, until RREADY.
  - One outstanding read at a time.
- Read and write to the same register in the same cycle: the read returns the old value.
- START: a committed write with bit0=1 and strobe[0]=1 pulses start_o in the cycle after commit and sets BUSY. If BUSY=1 already, START is ignored (no pulse).
- done_i: clears BUSY and sets DONE next edge. If a DONE W1C and done_i occur in the same cycle, set wins.
- irq_o = registered (DONE & IRQ_EN).
- csr_reg_o reflects register contents: reg1 shows the live status bits; reg0 bit0 always 0.

Decomposition:
- Package csr_pkg holds:
  - register index constants CTRL_IDX=0, STATUS_IDX=1
  - bit positions START_BIT=0, IRQ_EN_BIT=1, BUSY_BIT=0, DONE_BIT=1
  - AXI_RESP_OKAY=2'b00
- The CSR_REG_NUM/LOG2 defaults come from the global defines header.
- One natural sub-module, csr_regfile: strobed write port, combinational read port, status/start logic. The top keeps both AXI handshake FSMs.

Test Plan:
- Reset release then AW+W same cycle to addr 0x08, data 0xDEADBEEF, strb 4'hF -> AWREADY/WREADY 0 before the init edge; BVALID one cycle after handshake; a read of 0x08 returns 0xDEADBEEF with RRESP 0.
- W arrives 3 cycles before AW (addr 0x0C, data 0x11223344, strb 4'b0101 over 0xFFFFFFFF) -> WREADY drops after capture; reg3=0xFF22FF44; BRESP 0.
- BREADY held low 5 cycles -> BVALID stays 1, AWREADY/WREADY stay 0, no second write accepted; normal operation after BREADY.
- Write CTRL=0x3 -> start_o one-cycle pulse, STATUS=0x1; a second START write gives no pulse; done_i pulse -> STATUS=0x2, irq_o=1; write STATUS=0x2 -> STATUS=0, irq_o=0.
- Read and write of reg5 (old 0x0, new 0x55) handshake in the same cycle -> RDATA=0x0, a later read gives 0x55. Separately, RREADY low 4 cycles -> RDATA stable.
- rst_n asserted while BVALID=1 and RVALID=1 -> both 0 immediately, all registers 0, no start_o.
